// File: rtl/bcd_display_scan_pkg.sv
// Shared constants for the BCD display scanner: default geometry, internal
// decoder codes and active-low segment patterns {g,f,e,d,c,b,a}.
package bcd_display_scan_pkg;

    localparam int N_DIG_DEF       = 15;
    localparam int DISP_DEF        = 8;
    localparam int REFRESH_DIV_DEF = 100000;

    localparam logic [3:0] DP_NONE    = 4'hF;

    localparam logic [3:0] CODE_MINUS = 4'd10;
    localparam logic [3:0] CODE_E     = 4'd11;
    localparam logic [3:0] CODE_R     = 4'd12;
    localparam logic [3:0] CODE_BLANK = 4'd15;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_MINUS = 7'h3F;
    localparam logic [6:0] SEG_E     = 7'h06;
    localparam logic [6:0] SEG_R     = 7'h2F;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/bcd_display_scan_seg7.sv
// Combinational code-to-segment decoder. Codes 0-9 are digits, the rest are
// the special glyphs; anything unassigned is blank.
module seg7_decode
    import bcd_display_scan_pkg::*;
(
    input  logic [3:0] code_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        case (code_i)
            4'd0:       seg_o = SEG_0;
            4'd1:       seg_o = SEG_1;
            4'd2:       seg_o = SEG_2;
            4'd3:       seg_o = SEG_3;
            4'd4:       seg_o = SEG_4;
            4'd5:       seg_o = SEG_5;
            4'd6:       seg_o = SEG_6;
            4'd7:       seg_o = SEG_7;
            4'd8:       seg_o = SEG_8;
            4'd9:       seg_o = SEG_9;
            CODE_MINUS: seg_o = SEG_MINUS;
            CODE_E:     seg_o = SEG_E;
            CODE_R:     seg_o = SEG_R;
            default:    seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/bcd_display_scan.sv
// Multiplexed seven-segment scanner for a captured BCD result, with a
// scrollable window, leading-zero blanking, sign, decimal point and "Err".
module bcd_display_scan
    import bcd_display_scan_pkg::*;
#(
    parameter int N_DIG       = N_DIG_DEF,
    parameter int DISP        = DISP_DEF,
    parameter int REFRESH_DIV = REFRESH_DIV_DEF
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [4*N_DIG-1:0] i_bcd,
    input  logic               i_load,
    input  logic               i_neg,
    input  logic [3:0]         i_dp_pos,
    input  logic               i_err,
    input  logic               i_scroll_up,
    input  logic               i_scroll_dn,
    output logic [DISP-1:0]    o_an,
    output logic [6:0]         o_seg,
    output logic               o_dp,
    output logic [2:0]         o_offset
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int SW = (DISP > 1) ? $clog2(DISP) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_DIV - 1);
    localparam logic [SW-1:0] SCAN_LAST = SW'(DISP - 1);
    localparam logic [2:0]    OFF_MAX   = 3'(N_DIG - DISP);

    logic [4*N_DIG-1:0] bcd_q;
    logic               neg_q, err_q;
    logic [3:0]         dp_pos_q;
    logic [2:0]         offset_q, offset_d;
    logic [3:0]         msd_q, msd_d;
    logic [CW-1:0]      cnt_q;
    logic [SW-1:0]      scan_q;
    logic [DISP-1:0]    an_q, an_d;
    logic [6:0]         seg_q, seg_dec;
    logic               odp_q, odp_d;
    logic [4:0]         k;
    logic [3:0]         bound, nib, code;

    always_comb begin
        offset_d = offset_q;
        if (i_load)
            offset_d = 3'd0;
        else if (i_scroll_up && !i_scroll_dn && offset_q < OFF_MAX)
            offset_d = offset_q + 3'd1;
        else if (i_scroll_dn && !i_scroll_up && offset_q != 3'd0)
            offset_d = offset_q - 3'd1;
    end

    always_comb begin
        msd_d = 4'd0;
        for (int i = 0; i < N_DIG; i++)
            if (bcd_q[4*i +: 4] != 4'd0) msd_d = 4'(i);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            bcd_q    <= '0;
            neg_q    <= 1'b0;
            err_q    <= 1'b0;
            dp_pos_q <= DP_NONE;
            offset_q <= 3'd0;
            msd_q    <= 4'd0;
        end else begin
            if (i_load) begin
                bcd_q    <= i_bcd;
                neg_q    <= i_neg;
                err_q    <= i_err;
                dp_pos_q <= i_dp_pos;
            end
            offset_q <= offset_d;
            msd_q    <= msd_d;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            cnt_q  <= '0;
            scan_q <= '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_q  <= '0;
            scan_q <= (scan_q == SCAN_LAST) ? '0 : scan_q + SW'(1);
        end else begin
            cnt_q  <= cnt_q + CW'(1);
        end
    end

    // A decimal point to the left of the msd extends the visible digits, so
    // "0.25" keeps its leading zero.
    always_comb begin
        k     = 5'(offset_q) + 5'(scan_q);
        bound = msd_q;
        if (dp_pos_q != DP_NONE && dp_pos_q > msd_q) bound = dp_pos_q;
        nib = 4'd0;
        for (int i = 0; i < N_DIG; i++)
            if (k == 5'(i)) nib = bcd_q[4*i +: 4];
        code  = CODE_BLANK;
        odp_d = 1'b1;
        if (err_q) begin
            if (32'(scan_q) == 2)      code = CODE_E;
            else if (32'(scan_q) < 2)  code = CODE_R;
        end else begin
            if (k <= 5'(bound))
                code = (nib > 4'd9) ? CODE_BLANK : nib;
            else if (k == 5'(bound) + 5'd1 && neg_q)
                code = CODE_MINUS;
            if (dp_pos_q != DP_NONE && k == 5'(dp_pos_q)) odp_d = 1'b0;
        end
        an_d         = '1;
        an_d[scan_q] = 1'b0;
    end

    seg7_decode u_dec (
        .code_i (code),
        .seg_o  (seg_dec)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            an_q  <= '1;
            seg_q <= SEG_BLANK;
            odp_q <= 1'b1;
        end else begin
            an_q  <= an_d;
            seg_q <= seg_dec;
            odp_q <= odp_d;
        end
    end

    assign o_an     = an_q;
    assign o_seg    = seg_q;
    assign o_dp     = odp_q;
    assign o_offset = offset_q;

endmodule

// File: tb/tb_bcd_display_scan.sv
// Scoreboard bench for bcd_display_scan: each stimulus pushes the expected
// per-digit frame, which is popped as the DUT scans it out.
module tb_bcd_display_scan;

    localparam int N_DIG = 15;
    localparam int DISP  = 8;
    localparam int RDIV  = 4;

    logic               CLK = 1'b0;
    logic               RST = 1'b1;
    logic [4*N_DIG-1:0] i_bcd = '0;
    logic               i_load = 1'b0, i_neg = 1'b0, i_err = 1'b0;
    logic [3:0]         i_dp_pos = 4'hF;
    logic               i_scroll_up = 1'b0, i_scroll_dn = 1'b0;
    logic [DISP-1:0]    o_an;
    logic [6:0]         o_seg;
    logic               o_dp;
    logic [2:0]         o_offset;

    bcd_display_scan #(.N_DIG(N_DIG), .DISP(DISP), .REFRESH_DIV(RDIV)) dut (
        .CLK(CLK), .RST(RST), .i_bcd(i_bcd), .i_load(i_load), .i_neg(i_neg),
        .i_dp_pos(i_dp_pos), .i_err(i_err), .i_scroll_up(i_scroll_up),
        .i_scroll_dn(i_scroll_dn), .o_an(o_an), .o_seg(o_seg), .o_dp(o_dp),
        .o_offset(o_offset)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_err = 0;
    logic [15:0] exp_q[$];

    logic [6:0] tb_dig [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    localparam logic [6:0] T_MINUS = 7'h3F, T_E = 7'h06, T_R = 7'h2F, T_BLANK = 7'h7F;

    logic [4*N_DIG-1:0] m_bcd = '0;
    logic               m_neg = 1'b0, m_err = 1'b0;
    logic [3:0]         m_dp = 4'hF;
    int                 m_off = 0;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] model(int d);
        logic [6:0] seg;
        logic       dp;
        logic [3:0] nib;
        int k, msd, bnd;
        seg = T_BLANK;
        dp  = 1'b1;
        if (m_err) begin
            if (d == 2) seg = T_E;
            else if (d < 2) seg = T_R;
        end else begin
            k   = m_off + d;
            msd = 0;
            for (int i = 0; i < N_DIG; i++)
                if (m_bcd[4*i +: 4] != 4'd0) msd = i;
            bnd = msd;
            if (m_dp != 4'hF && int'(m_dp) > bnd) bnd = int'(m_dp);
            if (k <= bnd) begin
                nib = m_bcd[4*k +: 4];
                seg = (nib > 4'd9) ? T_BLANK : tb_dig[nib];
            end else if (k == bnd + 1 && m_neg) begin
                seg = T_MINUS;
            end
            if (m_dp != 4'hF && k == int'(m_dp)) dp = 1'b0;
        end
        return {~(8'h01 << d), seg, dp};
    endfunction

    task automatic push_frame();
        for (int d = 0; d < DISP; d++) exp_q.push_back(model(d));
    endtask

    task automatic do_load(logic [4*N_DIG-1:0] bcd, logic neg, logic [3:0] dp, logic err);
        i_bcd = bcd; i_neg = neg; i_dp_pos = dp; i_err = err; i_load = 1'b1;
        @(negedge CLK);
        i_load = 1'b0;
        m_bcd = bcd; m_neg = neg; m_dp = dp; m_err = err; m_off = 0;
        push_frame();
    endtask

    task automatic pulse(logic up, logic dn);
        i_scroll_up = up; i_scroll_dn = dn;
        @(negedge CLK);
        i_scroll_up = 1'b0; i_scroll_dn = 1'b0;
    endtask

    task automatic check_frame(string tag);
        int n;
        logic [15:0] e;
        logic [DISP-1:0] an0;
        repeat (3) @(negedge CLK);
        n = 0;
        while (o_an == 8'hFE && n < 100) begin @(negedge CLK); n++; end
        while (o_an != 8'hFE && n < 100) begin @(negedge CLK); n++; end
        if (n >= 100) begin
            chk({tag, " scan_timeout"}, 32'(n), 32'd0);
            while (exp_q.size() > 0) void'(exp_q.pop_front());
            return;
        end
        for (int d = 0; d < DISP; d++) begin
            if (exp_q.size() == 0) begin
                chk($sformatf("%s d%0d no_expect", tag, d), 32'({o_an, o_seg, o_dp}), 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                chk($sformatf("%s d%0d an/seg/dp", tag, d), 32'({o_an, o_seg, o_dp}), 32'(e));
            end
            an0 = o_an;
            n = 0;
            while (o_an == an0 && n < 20) begin @(negedge CLK); n++; end
            chk($sformatf("%s d%0d dwell", tag, d), 32'(n), 32'(RDIV));
        end
    endtask

    initial begin
        int d;
        #2 RST = 1'b0;
        @(negedge CLK);
        chk("reset an", 32'(o_an), 32'hFF);
        chk("reset seg", 32'(o_seg), 32'h7F);
        chk("reset dp", 32'(o_dp), 32'd1);
        chk("reset offset", 32'(o_offset), 32'd0);
        @(negedge CLK);
        RST = 1'b1;
        push_frame();
        check_frame("post_reset");

        do_load(60'h123456, 1'b0, 4'hF, 1'b0);
        chk("load offset", 32'(o_offset), 32'd0);
        check_frame("123456");
        do_load(60'h128, 1'b1, 4'hF, 1'b0);
        check_frame("neg128");
        do_load(60'h250, 1'b0, 4'd2, 1'b0);
        check_frame("2.50");
        do_load(60'h25, 1'b0, 4'd2, 1'b0);
        check_frame("0.25");
        do_load(60'hA3, 1'b1, 4'hF, 1'b0);
        check_frame("nibA");

        do_load(60'h987654321098765, 1'b0, 4'd9, 1'b0);
        check_frame("wide");
        for (int i = 0; i < 10; i++) pulse(1'b1, 1'b0);
        chk("scroll sat", 32'(o_offset), 32'd7);
        m_off = 7;
        push_frame();
        check_frame("off7");
        pulse(1'b0, 1'b1);
        chk("scroll dn", 32'(o_offset), 32'd6);
        pulse(1'b1, 1'b1);
        chk("scroll both", 32'(o_offset), 32'd6);
        for (int i = 0; i < 8; i++) pulse(1'b0, 1'b1);
        chk("scroll dn sat", 32'(o_offset), 32'd0);
        pulse(1'b1, 1'b0);
        pulse(1'b1, 1'b0);
        chk("scroll up2", 32'(o_offset), 32'd2);
        i_scroll_up = 1'b1;
        do_load(60'h987654321098765, 1'b1, 4'hF, 1'b0);
        i_scroll_up = 1'b0;
        chk("load+scroll", 32'(o_offset), 32'd0);
        check_frame("neg_wide");

        do_load(60'h555, 1'b1, 4'd1, 1'b1);
        for (int i = 0; i < 3; i++) pulse(1'b1, 1'b0);
        check_frame("err");
        do_load(60'h111111111111111, 1'b0, 4'hF, 1'b0);
        @(negedge CLK);
        d = 0;
        for (int i = 0; i < DISP; i++) if (o_an[i] == 1'b0) d = i;
        chk("err recover 2clk", 32'({o_an, o_seg, o_dp}), 32'(model(d)));
        check_frame("recover");

        repeat (5) @(negedge CLK);
        #2 RST = 1'b0;
        #1;
        chk("async an", 32'(o_an), 32'hFF);
        chk("async seg", 32'(o_seg), 32'h7F);
        chk("async dp", 32'(o_dp), 32'd1);
        chk("async offset", 32'(o_offset), 32'd0);
        @(negedge CLK);
        RST = 1'b1;
        m_bcd = '0; m_neg = 1'b0; m_err = 1'b0; m_dp = 4'hF; m_off = 0;
        push_frame();
        check_frame("after_async");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
